// File: rtl/debug_run_control.sv
// Run-control and breakpoint unit for the XM CPU debug front end: synchronises
// board keys/switches, gates CPU execution (halt/step/run) and compares PC against breakpoint slots.
module debug_run_control #(
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_BKPT   = 4,
   parameter int BSEL_W     = (NUM_BKPT > 1) ? $clog2(NUM_BKPT) : 1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  key_step_n,
   input  logic                  mode_cont,
   input  logic                  bkpt_wr,
   input  logic                  bkpt_clr,
   input  logic [BSEL_W-1:0]     bkpt_sel,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  instr_done,
   input  logic                  psw_slp,
   output logic                  cpu_run,
   output logic                  bkpt_hit,
   output logic [BSEL_W-1:0]     hit_idx,
   output logic [NUM_BKPT-1:0]   bkpt_valid,
   output logic [1:0]            state_out,
   output logic [1:0]            LEDR16_17,
   output logic                  LEDG7
);

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } state_t;

   // Bit order: 0 key_step_n, 1 mode_cont, 2 bkpt_wr, 3 bkpt_clr; key idles high.
   localparam logic [3:0] SYNC_IDLE = 4'b0001;

   logic [3:0]            meta_q, sync_q;
   logic                  key_prev_q, wr_prev_q, clr_prev_q;
   logic                  step_pulse_q, wr_pulse_q, clr_pulse_q;
   logic                  mode_s;
   state_t                state_q, state_d;
   logic                  resume_q, resume_d;
   logic [BSEL_W-1:0]     hit_idx_q, hit_idx_d;
   logic [NUM_BKPT-1:0]   valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q [NUM_BKPT];
   logic [ADDR_WIDTH-1:0] addr_d [NUM_BKPT];
   logic                  match_s;
   logic [BSEL_W-1:0]     match_idx_s;
   logic                  cpu_run_q, bkpt_hit_q, led_mode_q, ledg7_q;

   assign mode_s = sync_q[1];

   // Input synchronisers, edge history and registered edge pulses.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         meta_q       <= SYNC_IDLE;
         sync_q       <= SYNC_IDLE;
         key_prev_q   <= 1'b1;
         wr_prev_q    <= 1'b0;
         clr_prev_q   <= 1'b0;
         step_pulse_q <= 1'b0;
         wr_pulse_q   <= 1'b0;
         clr_pulse_q  <= 1'b0;
      end else begin
         meta_q       <= {bkpt_clr, bkpt_wr, mode_cont, key_step_n};
         sync_q       <= meta_q;
         key_prev_q   <= sync_q[0];
         wr_prev_q    <= sync_q[2];
         clr_prev_q   <= sync_q[3];
         step_pulse_q <= key_prev_q & ~sync_q[0];
         wr_pulse_q   <= ~wr_prev_q & sync_q[2];
         clr_pulse_q  <= ~clr_prev_q & sync_q[3];
      end
   end

   // Breakpoint slot update; a clear dominates a coincident write.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (clr_pulse_q) begin
         valid_d = '0;
      end else if (wr_pulse_q && (int'(bkpt_sel) < NUM_BKPT)) begin
         valid_d[bkpt_sel] = 1'b1;
         addr_d[bkpt_sel]  = addr_in;
      end else begin
         valid_d = valid_q;
      end
   end

   // Breakpoint compare; descending scan leaves the lowest matching slot.
   always_comb begin
      match_s     = 1'b0;
      match_idx_s = '0;
      for (int i = NUM_BKPT - 1; i >= 0; i--) begin
         if (instr_done && valid_q[i] && (pc == addr_q[i])) begin
            match_s     = 1'b1;
            match_idx_s = BSEL_W'(i);
         end else begin
            match_s     = match_s;
         end
      end
   end

   // Run-control next state.
   always_comb begin
      state_d   = state_q;
      resume_d  = resume_q;
      hit_idx_d = hit_idx_q;
      case (state_q)
         ST_HALT: begin
            if (step_pulse_q) begin
               if (mode_s) begin
                  state_d = ST_RUN;
               end else begin
                  state_d  = ST_STEP;
                  resume_d = 1'b0;
               end
            end else begin
               state_d = ST_HALT;
            end
         end
         ST_STEP: begin
            if (instr_done) begin
               state_d = resume_q ? ST_RUN : ST_HALT;
            end else begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (match_s) begin
               state_d   = ST_BREAK;
               hit_idx_d = match_idx_s;
            end else if (step_pulse_q) begin
               state_d = ST_HALT;
            end else if (instr_done && (psw_slp || !mode_s)) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_BREAK: begin
            // Resuming through STEP retires the breakpoint instruction without re-hitting it.
            if (step_pulse_q) begin
               state_d  = ST_STEP;
               resume_d = mode_s;
            end else begin
               state_d = ST_BREAK;
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   // State, breakpoint storage and registered outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= ST_HALT;
         resume_q   <= 1'b0;
         hit_idx_q  <= '0;
         valid_q    <= '0;
         for (int i = 0; i < NUM_BKPT; i++) addr_q[i] <= '0;
         cpu_run_q  <= 1'b0;
         bkpt_hit_q <= 1'b0;
         led_mode_q <= 1'b0;
         ledg7_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         resume_q   <= resume_d;
         hit_idx_q  <= hit_idx_d;
         valid_q    <= valid_d;
         addr_q     <= addr_d;
         cpu_run_q  <= (state_d == ST_RUN) || (state_d == ST_STEP);
         bkpt_hit_q <= (state_d == ST_BREAK);
         led_mode_q <= mode_s;
         ledg7_q    <= |valid_d;
      end
   end

   assign cpu_run    = cpu_run_q;
   assign bkpt_hit   = bkpt_hit_q;
   assign hit_idx    = hit_idx_q;
   assign bkpt_valid = valid_q;
   assign state_out  = state_q;
   assign LEDR16_17  = {led_mode_q, cpu_run_q};
   assign LEDG7      = ledg7_q;

endmodule

// File: doc/debug_run_control.md
# debug_run_control

Run-control and breakpoint unit for the XM CPU debug front end. Takes board switches and keys, plus the CPU's PC and retire strobe. It gates CPU execution through halt, single-step and continuous-run modes, with NUM_BKPT programmable address breakpoints. It sits between the board I/O and the CPU core, next to the memory/register viewer, and replaces the single-register, unclocked breakpoint/mode logic with a clocked FSM.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of PC, address switches and breakpoint slots
- NUM_BKPT, 4, number of breakpoint slots (1–16)
- BSEL_W, $clog2(NUM_BKPT) (min 1), slot index width

Ports:
- Clock  in  1  system clock; all state on rising edge
- Reset  in  1  synchronous, active-high; one clock, one reset
- key_step_n  in  1  raw active-low pushbutton: step / run / stop / resume
- mode_cont  in  1  raw switch: 1 = continuous, 0 = step
- bkpt_wr  in  1  raw switch; rising edge writes addr_in into slot bkpt_sel and enables it
- bkpt_clr  in  1  raw switch; rising edge disables all slots
- bkpt_sel  in  BSEL_W  slot select for writes
- addr_in  in  ADDR_WIDTH  breakpoint address from switches
- pc  in  ADDR_WIDTH  next-instruction address; valid when instr_done=1
- instr_done  in  1  one-cycle pulse per retired instruction
- psw_slp  in  1  PSW SLP bit
- cpu_run  out  1  execute enable to CPU (registered)
- bkpt_hit  out  1  high while in BREAK
- hit_idx  out  BSEL_W  slot that caused the last break
- bkpt_valid  out  NUM_BKPT  per-slot enable
- state_out  out  2  HALT=0, RUN=1, STEP=2, BREAK=3
- LEDR16_17  out  2  [0] executing (RUN or STEP), [1] synchronised mode_cont
- LEDG7  out  1  OR of bkpt_valid

## Operation
- key_step_n, mode_cont, bkpt_wr and bkpt_clr each pass a 2-flop synchroniser and then an edge register.
- step_pulse: one cycle on the falling edge of synced key_step_n.
- wr_pulse and clr_pulse: one cycle on the rising edges of the synced switches.
- bkpt_sel and addr_in are sampled directly on wr_pulse. They must be held static while switching.
- Slot write: bkpt_addr[bkpt_sel] <= addr_in and bkpt_valid[bkpt_sel] <= 1. If bkpt_sel >= NUM_BKPT, the write is ignored.
- clr_pulse clears all bkpt_valid bits; addresses are retained. If clr_pulse and wr_pulse coincide, clear wins and the write is dropped.
- Match: instr_done & bkpt_valid[i] & (pc == bkpt_addr[i]). hit_idx takes the lowest matching index.
- FSM (state register, reset HALT):
  - HALT: on step_pulse, go to RUN if mode_cont_s, else go to STEP with resume_cont=0. instr_done is ignored.
  - STEP: on instr_done, go to RUN if resume_cont, else go to HALT. Breakpoint match is ignored in STEP.
  - RUN, priority high to low:
    - match → BREAK, latch hit_idx.
    - step_pulse → HALT.
    - instr_done & psw_slp → HALT.
    - instr_done & !mode_cont_s → HALT.
  - BREAK: on step_pulse, go to STEP with resume_cont=mode_cont_s. This steps past the breakpoint address without re-hitting it.
- Breakpoints may be written or cleared in any state and take effect on the next compare.
- cpu_run <= (next_state == RUN) | (next_state == STEP).
- bkpt_hit <= (next_state == BREAK).
- LEDR16_17[0] tracks cpu_run. LEDR16_17[1] is registered mode_cont_s. LEDG7 <= |bkpt_valid_next.

## Timing
- Reset values: state HALT, cpu_run 0, bkpt_hit 0, hit_idx 0, bkpt_valid 0, bkpt_addr 0, LEDR16_17 2'b00, LEDG7 0, synchroniser flops at idle (key 1, switches 0).
- Raw input change sampled at edge k: the pulse is high in the cycle after edge k+2.
- Outputs update at the edge after the pulse, giving 4 edges from raw change to cpu_run / bkpt_valid change.
- instr_done at edge n with a transition: cpu_run changes at edge n+1. The CPU must sample cpu_run only at instruction fetch.
- A match at edge n gives bkpt_hit=1 and hit_idx valid from edge n+1.
- Reset mid-RUN: all outputs return to reset values at the next edge. Synchroniser history is cleared, so no spurious pulse follows reset.

## Test plan
- Reset, press key with mode_cont=0 → STEP, cpu_run=1. One instr_done → HALT, cpu_run=0 one edge later.
- Write slot 2=0x0040, then mode_cont=1, press key → RUN. instr_done with pc=0x0040 → BREAK, bkpt_hit=1, hit_idx=2, cpu_run=0.
- In BREAK press key with mode_cont=1 → STEP. instr_done with pc=0x0042 → RUN. The 0x0040 address is not re-hit.
- Slots 1 and 3 both =0x0100, match → hit_idx=1. Coincident bkpt_clr and bkpt_wr edges → bkpt_valid=0, LEDG7=0.
- RUN with psw_slp=1 on instr_done → HALT. In a separate run, match plus step_pulse in the same cycle → BREAK.
- Assert Reset during RUN with slots armed → state 0, cpu_run 0, bkpt_valid 0 at the next edge. No step pulse follows.
